// File: rtl/px16_line_framer_if.sv
// Pixel stream bundle around the line framer: s_* is the incoming 16-bit stream,
// m_* the regenerated line-marked stream. "slave" is the framer's view, "master" the environment's.
interface px16_line_framer_if;
  logic [15:0] s_data_i;
  logic        s_sof;
  logic        s_eof;
  logic        s_vld_i;
  logic        s_rdy_o;
  logic [15:0] m_data_o;
  logic        m_sof;
  logic        m_eof;
  logic        m_sol;
  logic        m_eol;
  logic        m_vld_o;
  logic        m_rdy_i;

  modport slave (
    input  s_data_i, s_sof, s_eof, s_vld_i, m_rdy_i,
    output s_rdy_o, m_data_o, m_sof, m_eof, m_sol, m_eol, m_vld_o
  );

  modport master (
    output s_data_i, s_sof, s_eof, s_vld_i, m_rdy_i,
    input  s_rdy_o, m_data_o, m_sof, m_eof, m_sol, m_eol, m_vld_o
  );
endinterface

// File: rtl/px16_line_framer.sv
// Enforces a fixed H_ACTIVE x V_ACTIVE geometry on a sof/eof pixel stream, regenerates
// frame and line markers, flags malformed frames and buffers the result in a small FIFO.
module px16_line_framer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  px16_line_framer_if.slave    bus,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic [15:0]          drop_cnt
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        sol;
    logic        eol;
  } entry_t;

  state_t          state, state_nxt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  entry_t          push_ent;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            full, empty, acc, pop, last_px, starts_frame;
  logic            push, drop, pos_clr, pos_start, pos_adv;
  logic            done_set, short_set, long_set;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign bus.s_rdy_o  = !rst && !full;
  assign acc          = bus.s_vld_i && bus.s_rdy_o;
  assign pop          = !empty && bus.m_rdy_i;
  assign last_px      = (x == X_LAST) && (y == Y_LAST);
  // A sof beat opens a frame from any state, except a sof+eof beat while flushing, which only ends the flush.
  assign starts_frame = bus.s_sof && ((state != FLUSH) || !bus.s_eof);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (acc) begin
      if (starts_frame) begin
        state_nxt = bus.s_eof ? IDLE : ACTIVE;
      end else begin
        unique case (state)
          ACTIVE: begin
            if (last_px)        state_nxt = bus.s_eof ? IDLE : FLUSH;
            else if (bus.s_eof) state_nxt = IDLE;
          end
          FLUSH:   if (bus.s_eof) state_nxt = IDLE;
          default: state_nxt = state;
        endcase
      end
    end
  end

  always_comb begin
    push      = 1'b0;
    drop      = 1'b0;
    pos_clr   = 1'b0;
    pos_start = 1'b0;
    pos_adv   = 1'b0;
    done_set  = 1'b0;
    short_set = 1'b0;
    long_set  = 1'b0;
    push_ent      = '0;
    push_ent.data = bus.s_data_i;
    if (acc) begin
      if (starts_frame) begin
        push          = 1'b1;
        push_ent.sof  = 1'b1;
        push_ent.sol  = 1'b1;
        push_ent.eof  = bus.s_eof;
        push_ent.eol  = bus.s_eof;
        short_set     = (state == ACTIVE) || bus.s_eof;
        done_set      = bus.s_eof;
        pos_clr       = bus.s_eof;
        pos_start     = !bus.s_eof;
      end else if (state == ACTIVE) begin
        push          = 1'b1;
        push_ent.sof  = (x == '0) && (y == '0);
        push_ent.sol  = (x == '0);
        push_ent.eof  = last_px || bus.s_eof;
        push_ent.eol  = (x == X_LAST) || bus.s_eof;
        done_set      = last_px || bus.s_eof;
        short_set     = !last_px && bus.s_eof;
        long_set      = last_px && !bus.s_eof;
        pos_clr       = last_px || bus.s_eof;
        pos_adv       = !(last_px || bus.s_eof);
      end else begin
        drop = 1'b1;
      end
    end
  end

  // The first pixel of a frame is pushed at (0,0), so the counter resumes at x=1.
  always_ff @(posedge clk) begin
    if (rst || pos_clr) begin
      x <= '0;
      y <= '0;
    end else if (pos_start) begin
      x <= XW'(1);
      y <= '0;
    end else if (pos_adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= done_set;
      err_short  <= short_set;
      err_long   <= long_set;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Outputs read as zero whenever the FIFO is empty so stale storage never leaks out.
  assign head         = mem[rd_ptr];
  assign bus.m_vld_o  = !empty;
  assign bus.m_data_o = empty ? 16'h0000 : head.data;
  assign bus.m_sof    = !empty && head.sof;
  assign bus.m_eof    = !empty && head.eof;
  assign bus.m_sol    = !empty && head.sol;
  assign bus.m_eol    = !empty && head.eol;

endmodule

// File: tb/tb_px16_line_framer.sv
// Self-checking bench for px16_line_framer: a hand-derived vector table, directed corner
// sequences and a randomized run, all compared against a pixel-index reference model.
module tb_px16_line_framer;

  localparam int H = 4;
  localparam int V = 2;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done, err_short, err_long;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  px16_line_framer_if bus ();

  px16_line_framer #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .frame_done (frame_done),
    .err_short  (err_short),
    .err_long   (err_long),
    .drop_cnt   (drop_cnt)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        sof;
    logic        eof;
    logic        sol;
    logic        eol;
  } ent_t;

  typedef struct {
    bit          vld, sof, eof;
    logic [15:0] data;
    bit          exp_vld;
    logic [15:0] exp_data;
    bit          exp_sof, exp_eof, exp_sol, exp_eol, exp_done;
  } vec_t;

  ent_t q[$];
  bit   in_frame, flushing;
  int   pix, drops;
  bit   e_done, e_short, e_long;
  int   vectors = 0;
  int   miscompares = 0;

  function automatic void model_reset();
    q.delete();
    in_frame = 0;
    flushing = 0;
    pix      = 0;
    drops    = 0;
    e_done   = 0;
    e_short  = 0;
    e_long   = 0;
  endfunction

  // Frame rules expressed on the running pixel index of the current frame.
  function automatic void model_beat(input bit sof, input bit eof, input logic [15:0] data);
    ent_t e;
    bit   last;
    e.data = data;
    if (in_frame && !sof) begin
      last  = (pix == H * V - 1);
      e.sof = (pix == 0);
      e.sol = (pix % H == 0);
      e.eol = (pix % H == H - 1) || eof;
      e.eof = last || eof;
      q.push_back(e);
      if (last) begin
        e_done   = 1;
        e_long   = !eof;
        flushing = !eof;
        in_frame = 0;
      end else if (eof) begin
        e_done   = 1;
        e_short  = 1;
        in_frame = 0;
      end else begin
        pix++;
      end
    end else if (sof && !(flushing && eof)) begin
      if (in_frame) e_short = 1;
      e.sof = 1; e.sol = 1; e.eof = eof; e.eol = eof;
      q.push_back(e);
      flushing = 0;
      if (eof) begin
        e_short  = 1;
        e_done   = 1;
        in_frame = 0;
      end else begin
        in_frame = 1;
        pix      = 1;
      end
    end else begin
      if (drops < 65535) drops++;
      if (flushing && eof) flushing = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    check("m_vld", 32'(bus.m_vld_o), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("m_data", 32'(bus.m_data_o), 32'(q[0].data));
      check("m_sof",  32'(bus.m_sof), 32'(q[0].sof));
      check("m_eof",  32'(bus.m_eof), 32'(q[0].eof));
      check("m_sol",  32'(bus.m_sol), 32'(q[0].sol));
      check("m_eol",  32'(bus.m_eol), 32'(q[0].eol));
    end
    check("s_rdy",      32'(bus.s_rdy_o), 32'(q.size() < D));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("err_short",  32'(err_short), 32'(e_short));
    check("err_long",   32'(err_long), 32'(e_long));
    check("drop_cnt",   32'(drop_cnt), 32'(drops));
  endtask

  task automatic apply_stimulus(input bit vld, input bit sof, input bit eof,
                                input logic [15:0] data, input bit rdy);
    bit acc, pop;
    bus.s_vld_i  = vld;
    bus.s_sof    = sof;
    bus.s_eof    = eof;
    bus.s_data_i = data;
    bus.m_rdy_i  = rdy;
    acc = vld && (q.size() < D);
    pop = (q.size() != 0) && rdy;
    e_done  = 0;
    e_short = 0;
    e_long  = 0;
    if (pop) void'(q.pop_front());
    if (acc) model_beat(sof, eof, data);
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_vld_i  = 1'b0;
    bus.s_sof    = 1'b0;
    bus.s_eof    = 1'b0;
    bus.s_data_i = 16'h0;
    bus.m_rdy_i  = 1'b0;
    @(posedge clk);
    #1;
    check("rst_s_rdy", 32'(bus.s_rdy_o), 0);
    check("rst_m_vld", 32'(bus.m_vld_o), 0);
    check("rst_m_data", 32'(bus.m_data_o), 0);
    check("rst_markers", 32'({bus.m_sof, bus.m_eof, bus.m_sol, bus.m_eol}), 0);
    check("rst_pulses", 32'({frame_done, err_short, err_long}), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 16'h0, 1);
  endtask

  task automatic send_frame(input int n, input int eof_at, input int base);
    for (int k = 1; k <= n; k++) apply_stimulus(1, k == 1, k == eof_at, 16'(base + k), 1);
  endtask

  initial begin
    vec_t        tbl [9];
    int          k, n_acc, n_out;
    logic [15:0] seen[$];
    bit          r, v;

    model_reset();
    do_reset();

    // Clean 4x2 frame, sink always ready: each pixel appears one cycle after its accept.
    tbl[0] = '{1, 1, 0, 16'd1, 1, 16'd1, 1, 0, 1, 0, 0};
    tbl[1] = '{1, 0, 0, 16'd2, 1, 16'd2, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 16'd3, 1, 16'd3, 0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 16'd4, 1, 16'd4, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 16'd5, 1, 16'd5, 0, 0, 1, 0, 0};
    tbl[5] = '{1, 0, 0, 16'd6, 1, 16'd6, 0, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 16'd7, 1, 16'd7, 0, 0, 0, 0, 0};
    tbl[7] = '{1, 0, 1, 16'd8, 1, 16'd8, 0, 1, 0, 1, 1};
    tbl[8] = '{0, 0, 0, 16'd0, 0, 16'd0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(tbl[i].vld, tbl[i].sof, tbl[i].eof, tbl[i].data, 1);
      check("tbl_vld", 32'(bus.m_vld_o), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld) begin
        check("tbl_data", 32'(bus.m_data_o), 32'(tbl[i].exp_data));
        check("tbl_markers", 32'({bus.m_sof, bus.m_eof, bus.m_sol, bus.m_eol}),
              32'({tbl[i].exp_sof, tbl[i].exp_eof, tbl[i].exp_sol, tbl[i].exp_eol}));
      end
      check("tbl_done", 32'(frame_done), 32'(tbl[i].exp_done));
    end
    check("tbl_drop_cnt", 32'(drop_cnt), 0);

    // Backpressure: sink stalled for 8 cycles, then released.
    k = 1;
    n_acc = 0;
    for (int c = 0; c < 8; c++) begin
      r = bus.s_rdy_o;
      apply_stimulus(1, k == 1, k == 8, 16'(k), 0);
      if (r) begin
        n_acc++;
        k++;
      end
    end
    check("bp_accepted", 32'(n_acc), 4);
    check("bp_rdy_low", 32'(bus.s_rdy_o), 0);
    for (int c = 0; c < 30; c++) begin
      r = bus.s_rdy_o;
      v = (k <= 8);
      if (bus.m_vld_o) seen.push_back(bus.m_data_o);
      apply_stimulus(v, v && k == 1, v && k == 8, 16'(k), 1);
      if (r && v) k++;
    end
    check("bp_out_count", 32'(seen.size()), 8);
    for (int i = 0; i < 8; i++) check("bp_order", 32'(seen[i]), 32'(i + 1));

    // Garbage before a frame is discarded and counted.
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 0, 16'(50 + i), 1);
    send_frame(8, 8, 0);
    idle(2);
    check("garbage_drops", 32'(drop_cnt), 3);

    // Short frame: eof on the fifth pixel.
    do_reset();
    for (int j = 1; j <= 5; j++) begin
      apply_stimulus(1, j == 1, j == 5, 16'(j), 1);
      if (j == 5) begin
        check("short_err", 32'(err_short), 1);
        check("short_done", 32'(frame_done), 1);
        check("short_eof_eol", 32'({bus.m_eof, bus.m_eol}), 32'(2'b11));
      end
    end
    idle(2);

    // Long frame: ten beats, geometry closes at eight, rest flushed.
    do_reset();
    for (int j = 1; j <= 10; j++) begin
      apply_stimulus(1, j == 1, j == 10, 16'(j), 1);
      if (j == 8) begin
        check("long_err", 32'(err_long), 1);
        check("long_eof", 32'(bus.m_eof), 1);
      end
    end
    idle(2);
    check("long_drops", 32'(drop_cnt), 2);
    send_frame(8, 8, 100);
    idle(2);

    // Reset in the middle of a stalled frame, then a clean frame.
    for (int j = 1; j <= 3; j++) apply_stimulus(1, j == 1, 0, 16'(20 + j), 0);
    do_reset();
    n_out = 0;
    for (int j = 1; j <= 11; j++) begin
      if (bus.m_vld_o) n_out++;
      apply_stimulus(j <= 8, j == 1, j == 8, 16'(j), 1);
    end
    check("rst_frame_count", 32'(n_out), 8);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                       $urandom_range(0, 8) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
